// File: rtl/mem_stage_dual.sv
// rtl/mem_stage_dual.sv - dual-lane memory-access stage with shared single-port data memory
//
// Purpose: takes two execute-stage lanes, performs at most one data-memory
// access per cycle, and registers writeback data for both lanes. When both
// lanes need memory in the same cycle the pair is serialised over two cycles
// (lane 1 first) and the upstream pipeline is stalled for the first cycle.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid1/2                     lane carries a valid instruction
//   alu_res1/2                      ALU result / byte address
//   store_data1/2                   store operand
//   dest_reg1/2                     destination register
//   MEM_READ1/2, MEM_WRITE1/2       load / store controls
//   REG_WRITE1/2                    register-file write controls
//   stall                           combinational upstream hold request
//   wb_valid1/2, wb_data1/2,
//   wb_reg1/2, wb_we1/2             registered writeback outputs
module mem_stage_dual #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid1,
  input  logic        in_valid2,
  input  logic [31:0] alu_res1,
  input  logic [31:0] alu_res2,
  input  logic [31:0] store_data1,
  input  logic [31:0] store_data2,
  input  logic [4:0]  dest_reg1,
  input  logic [4:0]  dest_reg2,
  input  logic        MEM_READ1,
  input  logic        MEM_READ2,
  input  logic        MEM_WRITE1,
  input  logic        MEM_WRITE2,
  input  logic        REG_WRITE1,
  input  logic        REG_WRITE2,
  output logic        stall,
  output logic        wb_valid1,
  output logic        wb_valid2,
  output logic [31:0] wb_data1,
  output logic [31:0] wb_data2,
  output logic [4:0]  wb_reg1,
  output logic [4:0]  wb_reg2,
  output logic        wb_we1,
  output logic        wb_we2
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] mem [0:DEPTH-1];

  logic              mem_op1;
  logic              mem_op2;
  logic              load1;
  logic              load2;
  logic              store1;
  logic              store2;
  logic [ADDR_W-1:0] idx1;
  logic [ADDR_W-1:0] idx2;
  logic              sel2;
  logic              mem_we;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       mem_wdata;
  logic [31:0]       rdata;
  logic [31:0]       lane1_data;
  logic [31:0]       lane2_data;

  logic              hold_valid;
  logic              hold_we;
  logic [31:0]       hold_data;
  logic [4:0]        hold_reg;

  // Byte-offset bits and address bits above the memory size are ignored,
  // so high addresses alias onto the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_res1[31:ADDR_W+2], alu_res1[1:0],
                              alu_res2[31:ADDR_W+2], alu_res2[1:0]};

  // A lane with both read and write set performs the write only.
  assign mem_op1 = in_valid1 & (MEM_READ1 | MEM_WRITE1);
  assign mem_op2 = in_valid2 & (MEM_READ2 | MEM_WRITE2);
  assign load1   = in_valid1 & MEM_READ1 & ~MEM_WRITE1;
  assign load2   = in_valid2 & MEM_READ2 & ~MEM_WRITE2;
  assign store1  = in_valid1 & MEM_WRITE1;
  assign store2  = in_valid2 & MEM_WRITE2;
  assign idx1    = alu_res1[ADDR_W+1:2];
  assign idx2    = alu_res2[ADDR_W+1:2];

  // Next state, stall and the single memory-port selection. stall depends
  // only on state and inputs, never on memory data.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    sel2       = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op1 && mem_op2) begin
          stall      = 1'b1;
          mem_we     = store1;
          state_next = SECOND;
        end else if (mem_op1) begin
          mem_we = store1;
        end else if (mem_op2) begin
          sel2   = 1'b1;
          mem_we = store2;
        end
      end
      SECOND: begin
        sel2       = 1'b1;
        mem_we     = store2;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A reset held across an edge blocks any write, dropping a pending lane 2 access.
  assign mem_wr     = mem_we & ~reset;
  assign mem_idx    = sel2 ? idx2 : idx1;
  assign mem_wdata  = sel2 ? store_data2 : store_data1;
  assign rdata      = mem[mem_idx];
  assign lane1_data = load1 ? rdata : alu_res1;
  assign lane2_data = load2 ? rdata : alu_res2;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_we    <= 1'b0;
      hold_data  <= 32'd0;
      hold_reg   <= 5'd0;
      wb_valid1  <= 1'b0;
      wb_valid2  <= 1'b0;
      wb_we1     <= 1'b0;
      wb_we2     <= 1'b0;
      wb_data1   <= 32'd0;
      wb_data2   <= 32'd0;
      wb_reg1    <= 5'd0;
      wb_reg2    <= 5'd0;
    end else begin
      state <= state_next;
      if (state == SECOND) begin
        wb_valid1 <= hold_valid;
        wb_we1    <= hold_we;
        wb_data1  <= hold_data;
        wb_reg1   <= hold_reg;
        wb_valid2 <= in_valid2;
        wb_we2    <= in_valid2 & REG_WRITE2;
        wb_data2  <= lane2_data;
        wb_reg2   <= dest_reg2;
      end else if (stall) begin
        // Park lane 1 and emit a bubble while lane 2 waits for the port.
        hold_valid <= in_valid1;
        hold_we    <= in_valid1 & REG_WRITE1;
        hold_data  <= lane1_data;
        hold_reg   <= dest_reg1;
        wb_valid1  <= 1'b0;
        wb_valid2  <= 1'b0;
        wb_we1     <= 1'b0;
        wb_we2     <= 1'b0;
        wb_data1   <= 32'd0;
        wb_data2   <= 32'd0;
        wb_reg1    <= 5'd0;
        wb_reg2    <= 5'd0;
      end else begin
        wb_valid1 <= in_valid1;
        wb_we1    <= in_valid1 & REG_WRITE1;
        wb_data1  <= lane1_data;
        wb_reg1   <= dest_reg1;
        wb_valid2 <= in_valid2;
        wb_we2    <= in_valid2 & REG_WRITE2;
        wb_data2  <= lane2_data;
        wb_reg2   <= dest_reg2;
      end
    end
  end

endmodule

// File: doc/mem_stage_dual.md
# mem_stage_dual

Dual-lane memory-access stage that sits directly downstream of the dual-issue execute stage and upstream of register writeback. Each lane receives an ALU result, a store operand and a destination register, performs an optional load or store against a shared single-port data memory, and registers the writeback data. When both lanes access memory in the same cycle, the stage serialises them over two cycles in program order (lane 1 first) and stalls the upstream pipeline.

## Interface
- ADDR_W, 8, word-address width; the memory holds 2^ADDR_W 32-bit words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid1, in_valid2  in  1  lane carries a valid instruction
- alu_res1, alu_res2  in  32  execute-stage ALU result (byte address for memory ops)
- store_data1, store_data2  in  32  register operand to store
- dest_reg1, dest_reg2  in  5  destination register selected in execute
- MEM_READ1, MEM_READ2  in  1  load
- MEM_WRITE1, MEM_WRITE2  in  1  store
- REG_WRITE1, REG_WRITE2  in  1  instruction writes the register file
- stall  out  1  combinational; upstream holds all inputs while high
- wb_valid1, wb_valid2  out  1  registered lane-valid
- wb_data1, wb_data2  out  32  registered writeback data
- wb_reg1, wb_reg2  out  5  registered destination
- wb_we1, wb_we2  out  1  registered register-file write enable

## Operation
- Memory: 2^ADDR_W x 32 array with combinational read and a write on the rising clk edge. One access per cycle. Word index = alu_res[ADDR_W+1:2]; bits [1:0] and the bits above ADDR_W+1 are ignored, so high addresses alias. Contents are not reset.
- Memory op of a lane: mem_opN = in_validN & (MEM_READN | MEM_WRITEN). If MEM_READN and MEM_WRITEN are both set, the lane performs a write only, and its wb_data is alu_res.
- wb_dataN = MEM_READN ? memory word : alu_resN. wb_weN = in_validN & REG_WRITEN. wb_regN = dest_regN.
- An invalid lane performs no memory access and produces wb_valid=0 and wb_we=0. Its wb_data and wb_reg are don't-care but must be registered deterministically.
- FSM states:
  - IDLE: if mem_op1 & mem_op2, assert stall, perform the lane 1 access, capture the lane 1 results into a holding register, go to SECOND. Otherwise perform whichever single access exists, register both lanes and stay in IDLE.
  - SECOND: stall low; perform the lane 2 access (inputs still held); register lane 1 from the holding register and lane 2 from the live access; go to IDLE.
- Program order: a lane 2 load issued after a lane 1 store to the same word returns the newly stored value. This applies both in the serialised case and when lane 1 stores and lane 2 performs a non-memory op (no conflict).
- Reset (any time): state goes to IDLE, the holding register clears, and all outputs go to 0. If reset arrives in SECOND, the lane 2 access is dropped. A lane 1 store already committed remains in memory.

## Timing
- Reset values: wb_valid1/2=0, wb_we1/2=0, wb_data1/2=0, wb_reg1/2=0, stall=0, state=IDLE.
- No conflict: latency 1. Inputs are sampled at edge k, results are visible after edge k, throughput is 1 instruction pair per cycle.
- Conflict: stall is high during cycle k (the IDLE cycle).
  - Edge k: the lane 1 store commits, or the lane 1 load is captured. Outputs after edge k carry a bubble: wb_valid1/2=0, wb_we1/2=0.
  - Edge k+1: the lane 2 access occurs. Both lanes' results are presented together after edge k+1.
- stall is never high in SECOND, so a new pair is accepted at edge k+1 only after it is released. Back-to-back conflicting pairs therefore cost 2 cycles each.
- Stall depends only on the current state and the current inputs; there is no combinational path from memory data to stall.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, stall=0. Release reset and issue lane 1 ADD with alu_res1=0x15, REG_WRITE1=1, dest_reg1=3 -> the next cycle shows wb_valid1=1, wb_data1=0x15, wb_reg1=3, wb_we1=1.
- Single-lane store then load: lane 1 stores 0xDEADBEEF to address 0x40. The next pair has lane 2 load 0x40 into r9 and lane 1 invalid -> wb_data2=0xDEADBEEF, wb_reg2=9, stall never asserted.
- Dual conflict ordering: lane 1 stores 0x12345678 to address 0x80 and lane 2 loads address 0x80 in the same cycle -> stall=1 for exactly one cycle, then one bubble, then wb_data2=0x12345678 with wb_valid1=wb_valid2=1.
- Dual loads: memory holds [0x10]=0xA and [0x14]=0xB; lane 1 loads 0x10 into r4 and lane 2 loads 0x14 into r5 -> after 2 cycles, wb_data1=0xA, wb_reg1=4, wb_data2=0xB, wb_reg2=5.
- Aliasing/alignment with ADDR_W=8: store 0x55 to address 0x403, then load 0x000 -> 0x55.
- Reset in SECOND: during the conflict pair (lane 1 stores 0x1 to 0x20, lane 2 stores 0x2 to 0x24), pulse reset in the cycle after stall -> later loads return [0x20]=0x1 and [0x24] unchanged.
